// File: rtl/seg7_capture_decoder.sv
// Samples a 7-segment bus, debounces it, and decodes stable glyphs back to hex digits.
// Optional macro SEG_ACTIVE_LOW_EN inverts the synchronized input for common-anode displays.
`timescale 1ns/1ps
module seg7_capture_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit,
  output logic             digit_valid,
  input  logic             digit_ready,
  output logic             invalid,
  output logic             overflow,
  output logic [CNT_W-1:0] change_count,
  output logic             locked
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned STB_W = 8;
  localparam int unsigned DIG_W = 4;

  typedef enum logic {SETTLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [SEG_W-1:0] sync1_q, sync2_q;
  logic [SEG_W-1:0] cand_q, cand_d;
  logic [SEG_W-1:0] acc_q, acc_d;
  logic [STB_W-1:0] stb_q, stb_d;
  logic [DIG_W-1:0] digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             invalid_q, invalid_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cc_q, cc_d;

  logic [SEG_W-1:0] seg_s_c;
  logic [DIG_W-1:0] dec_digit_c;
  logic             dec_legal_c;
  logic             stable_c;
  logic             diff_c;
  logic             accept_c;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_s_c = ~sync2_q;
`else
  assign seg_s_c = sync2_q;
`endif

  // Glyph decode of the candidate being accepted
  always_comb begin
    dec_digit_c = '0;
    dec_legal_c = 1'b1;
    case (cand_q)
      7'h3F: dec_digit_c = 4'h0;
      7'h06: dec_digit_c = 4'h1;
      7'h5B: dec_digit_c = 4'h2;
      7'h4F: dec_digit_c = 4'h3;
      7'h66: dec_digit_c = 4'h4;
      7'h6D: dec_digit_c = 4'h5;
      7'h7D: dec_digit_c = 4'h6;
      7'h07: dec_digit_c = 4'h7;
      7'h7F: dec_digit_c = 4'h8;
      7'h6F: dec_digit_c = 4'h9;
      7'h77: dec_digit_c = 4'hA;
      7'h7C: dec_digit_c = 4'hB;
      7'h39: dec_digit_c = 4'hC;
      7'h5E: dec_digit_c = 4'hD;
      7'h79: dec_digit_c = 4'hE;
      7'h71: dec_digit_c = 4'hF;
      default: dec_legal_c = 1'b0;
    endcase
  end

  assign stable_c = (stb_q == STB_W'(STABLE_CYCLES));
  assign diff_c   = sample_en && (seg_s_c != cand_q);
  assign accept_c = stable_c && (cand_q != acc_q);

  // Filter, FSM next state, acceptance and handshake
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    stb_d     = stb_q;
    acc_d     = acc_q;
    digit_d   = digit_q;
    valid_d   = valid_q;
    invalid_d = invalid_q;
    ovf_d     = ovf_q;
    cc_d      = cc_q;

    if (sample_en) begin
      if (diff_c) begin
        cand_d = seg_s_c;
        stb_d  = STB_W'(1);
      end else if (!stable_c) begin
        stb_d = stb_q + STB_W'(1);
      end
    end

    case (state_q)
      SETTLE: if (stable_c && !diff_c) state_d = LOCKED;
      LOCKED: if (diff_c) state_d = SETTLE;
      default: state_d = SETTLE;
    endcase

    if (valid_q && digit_ready) valid_d = 1'b0;

    // Acceptance uses the registered candidate; a new sample may arrive the same cycle
    if (accept_c) begin
      acc_d = cand_q;
      cc_d  = cc_q + CNT_W'(1);
      if (!dec_legal_c) begin
        invalid_d = 1'b1;
      end else if (!valid_q || digit_ready) begin
        digit_d = dec_digit_c;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SETTLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      acc_q     <= '0;
      stb_q     <= '0;
      digit_q   <= '0;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
      ovf_q     <= 1'b0;
      cc_q      <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= seg_in;
      sync2_q   <= sync1_q;
      cand_q    <= cand_d;
      acc_q     <= acc_d;
      stb_q     <= stb_d;
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      invalid_q <= invalid_d;
      ovf_q     <= ovf_d;
      cc_q      <= cc_d;
    end
  end

  assign digit        = digit_q;
  assign digit_valid  = valid_q;
  assign invalid      = invalid_q;
  assign overflow     = ovf_q;
  assign change_count = cc_q;
  assign locked       = (state_q == LOCKED);

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Scoreboard bench for seg7_capture_decoder: directed glyph sequences, delivered digits checked by a monitor.
`timescale 1ns/1ps
module tb_seg7_capture_decoder;

  logic       clk;
  logic       rst;
  logic       sample_en;
  logic [6:0] seg_in;
  logic       digit_ready;

  logic [3:0] digit, digit2;
  logic       digit_valid, digit_valid2;
  logic       invalid, invalid2;
  logic       overflow, overflow2;
  logic [7:0] change_count;
  logic [1:0] change_count2;
  logic       locked, locked2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];
  logic [7:0] cc_exp;

  seg7_capture_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .seg_in(seg_in),
    .digit(digit), .digit_valid(digit_valid), .digit_ready(digit_ready),
    .invalid(invalid), .overflow(overflow), .change_count(change_count),
    .locked(locked)
  );

  seg7_capture_decoder #(.STABLE_CYCLES(4), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .sample_en(sample_en), .seg_in(seg_in),
    .digit(digit2), .digit_valid(digit_valid2), .digit_ready(digit_ready),
    .invalid(invalid2), .overflow(overflow2), .change_count(change_count2),
    .locked(locked2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every transfer (valid & ready) must match the next queued digit
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && digit_valid && digit_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_digit", {28'd0, digit}, 32'hFFFF_FFFF);
        end else begin
          check("digit_xfer", {28'd0, digit}, {28'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_digit"},  {28'd0, digit}, 32'd0);
    check({tag, "_valid"},  {31'd0, digit_valid}, 32'd0);
    check({tag, "_invalid"},{31'd0, invalid}, 32'd0);
    check({tag, "_ovf"},    {31'd0, overflow}, 32'd0);
    check({tag, "_cc"},     {24'd0, change_count}, 32'd0);
    check({tag, "_cc_w2"},  {30'd0, change_count2}, 32'd0);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b1; seg_in = 7'h00; digit_ready = 1'b0;
    cc_exp = 8'd0;
    step(2);
    rst = 1'b0;
    check_reset_state("reset");

    // 1: glyph 1 held, valid rises exactly 7 cycles after the input change
    step(1);
    seg_in = 7'h06;
    exp_q.push_back(4'h1);
    step(6);
    check("lat_not_yet", {31'd0, digit_valid}, 32'd0);
    step(1);
    cc_exp = cc_exp + 8'd1;
    check("lat_valid", {31'd0, digit_valid}, 32'd1);
    check("lat_digit", {28'd0, digit}, 32'h1);
    check("lat_cc", {24'd0, change_count}, {24'd0, cc_exp});
    check("lat_locked", {31'd0, locked}, 32'd1);
    digit_ready = 1'b1;
    step(1);
    digit_ready = 1'b0;
    check("drain_valid", {31'd0, digit_valid}, 32'd0);

    // 2: two-sample glitch to 0x7F then back to 0x06
    seg_in = 7'h7F;
    step(2);
    seg_in = 7'h06;
    step(1);
    check("glitch_unlocked", {31'd0, locked}, 32'd0);
    step(6);
    check("glitch_relocked", {31'd0, locked}, 32'd1);
    check("glitch_valid", {31'd0, digit_valid}, 32'd0);
    check("glitch_cc", {24'd0, change_count}, {24'd0, cc_exp});

    // 3: illegal glyph 0x49
    seg_in = 7'h49;
    step(7);
    cc_exp = cc_exp + 8'd1;
    check("illegal_invalid", {31'd0, invalid}, 32'd1);
    check("illegal_valid", {31'd0, digit_valid}, 32'd0);
    check("illegal_cc", {24'd0, change_count}, {24'd0, cc_exp});

    // 4: backpressure: 2 held, 3 overflows, then 4 loads while 2 is consumed
    seg_in = 7'h5B;
    exp_q.push_back(4'h2);
    step(7);
    cc_exp = cc_exp + 8'd1;
    check("bp_valid", {31'd0, digit_valid}, 32'd1);
    check("bp_digit2", {28'd0, digit}, 32'h2);
    seg_in = 7'h4F;
    step(7);
    cc_exp = cc_exp + 8'd1;
    check("bp_digit_held", {28'd0, digit}, 32'h2);
    check("bp_overflow", {31'd0, overflow}, 32'd1);
    check("bp_cc", {24'd0, change_count}, {24'd0, cc_exp});
    seg_in = 7'h66;
    exp_q.push_back(4'h4);
    step(6);
    digit_ready = 1'b1;
    step(1);
    cc_exp = cc_exp + 8'd1;
    check("bp_reload_valid", {31'd0, digit_valid}, 32'd1);
    check("bp_reload_digit", {28'd0, digit}, 32'h4);
    check("bp_reload_cc", {24'd0, change_count}, {24'd0, cc_exp});
    step(1);
    digit_ready = 1'b0;
    check("bp_drained", {31'd0, digit_valid}, 32'd0);
    check("invalid_sticky", {31'd0, invalid}, 32'd1);

    // 5: reset mid-settle (counter at 2) discards the candidate
    seg_in = 7'h3F;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_reset_state("midrst");
    cc_exp = 8'd0;
    exp_q.push_back(4'h0);
    step(6);
    check("midrst_not_yet", {31'd0, digit_valid}, 32'd0);
    step(1);
    cc_exp = cc_exp + 8'd1;
    check("midrst_valid", {31'd0, digit_valid}, 32'd1);
    check("midrst_cc", {24'd0, change_count}, {24'd0, cc_exp});

    // 6: counter wrap on the 2-bit instance over five alternating accepts
    digit_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seg_in = (i % 2 == 0) ? 7'h06 : 7'h3F;
      exp_q.push_back((i % 2 == 0) ? 4'h1 : 4'h0);
      step(7);
      cc_exp = cc_exp + 8'd1;
      check("wrap_cc", {24'd0, change_count}, {24'd0, cc_exp});
      check("wrap_cc_w2", {30'd0, change_count2}, {30'd0, cc_exp[1:0]});
    end
    check("wrap_final_w2", {30'd0, change_count2}, 32'd1);
    step(3);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("final_overflow_w2", {31'd0, overflow2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_capture_decoder.md
Name: seg7_capture_decoder

Overview:
- Receive-side counterpart of the display path: samples a 7-segment pattern (as driven by the display block onto pins), filters glitches, and decodes it back into a 4-bit hex digit.
- Delivers each newly accepted digit through a valid/ready handshake and keeps change and error statistics.
- Used for loopback self-test of the display chain (uio_in driven from display segments) and as a generic segment-bus monitor.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical qualified samples required before a pattern is accepted (legal range 1..255).
- CNT_W, 8, width of the change counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sample_en  input  1  sampling strobe (e.g. divided-clock tick); samples are qualified only when high.
- seg_in  input  7  raw segment pattern; bit0=a … bit6=g, active-high.
- digit  output  4  decoded hex digit 0x0..0xF.
- digit_valid  output  1  digit holds an undelivered value.
- digit_ready  input  1  consumer accepts digit when high together with digit_valid.
- invalid  output  1  sticky: an accepted pattern was not a legal hex glyph.
- overflow  output  1  sticky: an accepted digit was dropped because the output slot was full.
- change_count  output  CNT_W  number of accepted pattern changes; wraps modulo 2^CNT_W.
- locked  output  1  high while the current sampled pattern equals the last accepted one.

Behaviour:
- Input path: 2-flop synchronizer on seg_in (always clocked, not gated by sample_en). The filter sees only the synchronized value, sampled when sample_en=1.
- Filter: candidate register plus stability counter.
  - On a qualified sample that differs from candidate: candidate <= sample, counter <= 1.
  - On a qualified sample that equals candidate: counter increments, saturating at STABLE_CYCLES.
- Acceptance: fires in the cycle the counter reaches STABLE_CYCLES and candidate != accepted pattern.
  - With STABLE_CYCLES=1, the first differing sample is accepted immediately.
- FSM states:
  - SETTLE: waiting for stability; locked=0.
  - LOCKED: candidate == accepted; locked=1.
  - SETTLE->LOCKED on acceptance, or when the counter reaches STABLE_CYCLES with candidate == accepted (bounce back to the old glyph: no event).
  - LOCKED->SETTLE on any differing qualified sample.
- Decode table, pattern -> digit: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9, 0x77->A, 0x7C->b, 0x39->C, 0x5E->d, 0x79->E, 0x71->F.
  - Any other pattern on acceptance: invalid<=1 (sticky until reset), no digit emitted, change_count still increments, accepted pattern still updated.
- On acceptance of a legal glyph:
  - change_count++.
  - If the slot is empty, or being consumed this cycle (digit_valid&digit_ready): digit <= decoded, digit_valid <= 1.
  - If the slot is full and not being consumed: digit unchanged, overflow<=1 (sticky).
- Handshake:
  - digit_valid deasserts the cycle after digit_valid&digit_ready, unless a new digit loads in the same cycle.
  - digit is stable while digit_valid=1.
- Latency: new stable pattern on seg_in -> digit_valid high = 2 sync cycles + STABLE_CYCLES qualified samples + 1 register cycle.
- Reset (synchronous, wins over every other event):
  - digit=0, digit_valid=0, invalid=0, overflow=0, change_count=0, locked=0.
  - State=SETTLE, candidate=0x00, counter=0, accepted pattern=0x00, synchronizer=0.
  - Reset mid-settle discards the pending candidate.
- Pattern 0x00 (blank) is illegal. Because accepted resets to 0x00, a blank display after reset produces no event.

Optional Feature:
- SEG_ACTIVE_LOW_EN
  - Defined: seg_in is inverted after the synchronizer (common-anode displays). All decode values and stability rules apply to the inverted value; a reset-state input of 0x7F decodes as blank, so it produces no event.
  - Undefined: seg_in is used as-is, active-high.

Test Plan:
- Reset then seg_in=0x06 held, sample_en=1 every cycle, STABLE_CYCLES=4, digit_ready=0 -> digit_valid rises 7 cycles after the input change; digit=0x1, change_count=1, locked=1.
- Glitch: seg_in 0x06 -> 0x7F for 2 samples -> back to 0x06 -> no new digit_valid, change_count unchanged, locked drops then returns to 1.
- Illegal 0x49 held 4 samples -> invalid=1, digit_valid unchanged, change_count+1; invalid stays 1 until rst.
- Backpressure: digit_ready=0, accept 0x5B (2) then 0x4F (3) -> digit stays 0x2, overflow=1. Then digit_ready=1 with a simultaneous accept of 0x66 -> digit=0x4, valid stays 1.
- Counter wrap with CNT_W=2: 5 alternating accepts 0x3F/0x06 -> change_count=1.
- rst pulsed for one cycle mid-settle (counter=2) -> all outputs reset next cycle; the same held pattern needs a full 4 qualified samples to accept.
